// File: rtl/sw_input_ctrl.sv
// Avalon-MM slide-switch input port: 2-flop sync, per-bit debounce, edge capture and maskable irq.
// Define SW_INPUT_CTRL_DEBOUNCE_EN to build the tick prescaler and per-bit debounce counters.
module sw_input_ctrl #(
  parameter int WIDTH        = 10,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_toggle;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] edge_clr;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] edge_q;
  logic [1:0]       mode;
  logic             wr_en;
  logic [31:0]      rd_mux;
  logic             unused_wd;

  assign wr_en     = chipselect && !write_n;
  assign unused_wd = ^writedata[31:WIDTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      s     <= '0;
    end else begin
      sync1 <= in_port;
      s     <= sync1;
    end
  end

`ifdef SW_INPUT_CTRL_DEBOUNCE_EN
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0]           pcount;
  logic                    tick;
  logic [WIDTH-1:0][3:0]   c;

  assign tick = (pcount == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  pcount <= '0;
    else if (tick) pcount <= '0;
    else           pcount <= pcount + 1'b1;
  end

  always_comb begin
    q_toggle = '0;
    for (int i = 0; i < WIDTH; i++)
      q_toggle[i] = tick && (s[i] != q[i]) && (c[i] == 4'(STABLE_TICKS - 1));
  end

  // A tick where s already matches q breaks the run, so bounces never accumulate.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c <= '0;
      q <= '0;
    end else begin
      q <= q ^ q_toggle;
      for (int i = 0; i < WIDTH; i++) begin
        if (tick) begin
          if (s[i] != q[i]) c[i] <= q_toggle[i] ? 4'd0 : c[i] + 4'd1;
          else              c[i] <= 4'd0;
        end
      end
    end
  end
`else
  localparam int unused_cfg = TICK_DIV + STABLE_TICKS;

  assign q_toggle = s ^ q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q <= '0;
    else          q <= s;
  end
`endif

  // q_toggle & ~q is a rising edge (q about to go 1), q_toggle & q is falling.
  assign edge_set = (mode[0] ? (q_toggle & ~q) : '0) | (mode[1] ? (q_toggle & q) : '0);
  assign edge_clr = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask   <= '0;
      mode   <= 2'b11;
      edge_q <= '0;
    end else begin
      edge_q <= (edge_q & ~edge_clr) | edge_set;
      if (wr_en && address == 2'd1) mask <= writedata[WIDTH-1:0];
      if (wr_en && address == 2'd3) mode <= writedata[1:0];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[WIDTH-1:0] = q;
      2'd1:    rd_mux[WIDTH-1:0] = mask;
      2'd2:    rd_mux[WIDTH-1:0] = edge_q;
      default: rd_mux[1:0]       = mode;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

  assign irq = |(edge_q & mask);

endmodule

// File: doc/sw_input_ctrl.md
# sw_input_ctrl

Avalon-MM slave controller for the 10-bit slide-switch input port of the Nios display system. It synchronizes and debounces the raw switch lines and latches selected edges in a capture register. It raises a maskable interrupt so firmware reacts to switch changes without polling. It sits between the board switch pins and the Nios data master.

## Interface
- WIDTH, 10: number of switch inputs.
- TICK_DIV, 50000: clk cycles per debounce sample tick (1 ms at 50 MHz); ≥2.
- STABLE_TICKS, 8: consecutive mismatching ticks required to accept a new level; 1..15.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous reset, active-low.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- in_port  in  WIDTH  raw asynchronous switch lines.
- irq  out  1  interrupt request, active-high, level.

## Operation
- Register map:
  - 0 DATA (RO): debounced state, zero-extended.
  - 1 MASK (RW): per-bit irq enable, WIDTH bits.
  - 2 EDGE (R/W1C): captured edges; writing 1 clears that bit.
  - 3 MODE (RW): bits[1:0]; 00 none, 01 rising, 10 falling, 11 both.
- Write occurs when chipselect=1 and write_n=0. Writes to address 0 are ignored. Unused writedata bits are ignored.
- Synchronizer: two flops per bit; sync output is `s`.
- Prescaler: counter 0..TICK_DIV-1, wraps. `tick` is a one-cycle pulse when count = TICK_DIV-1.
- Per bit: stable state `q` and a 4-bit counter `c`.
  - On tick with s≠q: if c = STABLE_TICKS-1, then q toggles and c clears; otherwise c increments.
  - On tick with s=q: c clears.
  - No change between ticks.
- Edge detect uses the q toggle. A rising edge is q 0→1; a falling edge is q 1→0. An edge sets its EDGE bit when MODE enables that polarity.
- EDGE set has priority over a W1C clear in the same cycle.
- irq = |(EDGE & MASK), decoded from flops only, so no glitches.
- Reset values: readdata 0, irq 0, q 0, c 0, prescaler 0, synchronizers 0, MASK 0, EDGE 0, MODE 2'b11.
  - Reset assertion mid-debounce discards the pending count.
  - Switches held high during reset produce a rising edge after release.

## Timing
- readdata is registered. It is loaded every cycle from the address mux regardless of chipselect, giving read latency 1 and no wait states.
  - Unused upper bits read 0.
  - MODE reads as {30'b0, mode}.
- A register write is visible to a read issued the next cycle.
- Worst-case input-to-DATA latency: 2 sync cycles + STABLE_TICKS×TICK_DIV cycles.
- Minimum latency: 2 + (STABLE_TICKS-1)×TICK_DIV + 1 cycles.
- An EDGE bit sets in the same cycle q toggles. irq asserts on that clock edge when the bit is masked in.
- irq deasserts the cycle after a W1C write clears the last masked pending bit, or after the MASK write that disables it.
- A bounce shorter than STABLE_TICKS consecutive ticks produces no q change and no edge.

## Configuration
- SW_INPUT_CTRL_DEBOUNCE_EN defined: the prescaler and per-bit counters are present, as described above.
- SW_INPUT_CTRL_DEBOUNCE_EN undefined:
  - Prescaler and counters are removed.
  - q <= s every clock, so DATA latency is 3 cycles from in_port.
  - Edge capture, MASK, MODE and irq behave identically, but are driven from the undebounced q.
  - TICK_DIV and STABLE_TICKS are ignored.

## Test plan
All scenarios use TICK_DIV=4, STABLE_TICKS=3, DEBOUNCE_EN defined.
- Reset: assert reset_n=0 mid-run → readdata=0, irq=0, MODE reads 3, MASK/EDGE read 0.
- Clean press: set in_port=10'h001 and hold → DATA reads 0x001 within 2+12 cycles. EDGE=0x001. irq stays 0 while MASK=0.
- Bounce reject: bit 3 toggles every 5 cycles for 40 cycles, then returns to 0 → DATA bit 3 stays 0, EDGE=0.
- Interrupt flow:
  - MASK=0x3FF, release bit 0 with MODE=10 → EDGE=0x001, irq=1.
  - Write EDGE=0x001 → irq=0 next cycle.
  - With MODE=01, a release sets no edge.
- Collision: W1C write of bit 5 in the same cycle bit 5 sees a new edge → EDGE bit 5 remains 1, irq stays 1.
- Macro undefined: in_port=10'h2AA → DATA reads 0x2AA after 3 cycles. EDGE=0x2AA with MODE=11.
